int_ctrl_multi: RTL and testbench
=================================

// Module: int_ctrl_multi
// PURPOSE
//   Parametrised interrupt controller between NUM_SRC external interrupt lines and the core's single int input.
//   Per-source synchronisation, edge/level mode, enable mask and pending latch; fixed priority (lowest index wins).
//   Drives one request to the core with a vector-table address. Holds the in-service source until the core retires RTI.
//   Single level, no nesting. Core-side handshake: int_out / int_ack / rti_done.
// PARAMETERS
//   NUM_SRC      4      number of interrupt sources, 1..DATA_W
//   DATA_W       8      datapath / address / config register width
//   VEC_BASE     8'h01  memory address of vector-table entry for source 0
//   SYNC_STAGES  2      synchroniser depth on each irq_in bit, >=2
// PORTS
//   clk        in   1          core clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   irq_in     in   NUM_SRC    raw interrupt lines, asynchronous to clk
//   cfg_we     in   1          config write strobe, one cycle
//   cfg_addr   in   2          0=ENABLE 1=MODE 2=PEND 3=STATUS
//   cfg_wdata  in   DATA_W     config write data, bits [NUM_SRC-1:0] used
//   cfg_rdata  out  DATA_W     registered read data for cfg_addr
//   int_out    out  1          interrupt request to core
//   int_ack    in   1          core accepts request, one-cycle pulse
//   vec_addr   out  DATA_W     VEC_BASE + winning source id
//   rti_done   in   1          core retired RTI, one-cycle pulse
//   busy       out  1          high in REQ or SERVICE
// BEHAVIOUR
//   Reset: ENABLE=0, MODE=0 (all level), PEND=0, sync/prev flops=0, state=IDLE, int_out=0, busy=0,
//     vec_addr=VEC_BASE, cfg_rdata=0. Reset mid-REQ/SERVICE abandons the interrupt; no pulse survives.
//   Sync: each irq_in bit through SYNC_STAGES flops, then one prev flop; edge = sync & ~prev.
//   PEND[i]: edge mode (MODE[i]=1): set on edge regardless of ENABLE; cleared by int_ack for the winner or by
//     W1C write to addr 2. Same-cycle set and clear -> set wins. Level mode: PEND[i] = synced level (read-only).
//   Eligible = PEND & ENABLE. Winner = lowest index set bit.
//   Latency: irq_in high at edge k -> PEND at edge k+SYNC_STAGES -> int_out=1 after edge k+SYNC_STAGES+1.
//   FSM IDLE: eligible!=0 -> REQ; latch id, vec_addr=VEC_BASE+id (mod 2^DATA_W), int_out=1.
//   FSM REQ: winner frozen, no re-arbitration. int_ack -> SERVICE, int_out=0, clear edge PEND[id].
//     Latched id no longer eligible (masked, W1C, level dropped) and no ack this cycle -> IDLE, int_out=0.
//     ack in the same cycle as withdrawal -> ack wins.
//   FSM SERVICE: int_out=0; new pends latch but are not requested. rti_done -> IDLE; re-arbitrates next cycle.
//     int_ack in IDLE/SERVICE and rti_done in IDLE/REQ are ignored.
//   vec_addr holds from REQ entry through SERVICE until next REQ entry.
//   Config: writes take effect next edge; ENABLE/MODE full write; PEND write-1-to-clear; STATUS read-only.
//     MODE change level->edge clears that PEND bit. cfg_rdata updates one cycle after cfg_addr.
//   STATUS = {busy, in_service, id}, zero-padded to DATA_W.
// TESTING
//   T1 reset: rst=1 mid-SERVICE -> int_out=0, busy=0, vec_addr=8'h01, all cfg regs read 0.
//   T2 single edge: ENABLE=4'b0100, MODE=4'b0100, pulse irq_in[2] -> int_out rises 3 cycles later, vec_addr=8'h03;
//      int_ack -> int_out=0, PEND[2]=0; rti_done -> busy=0.
//   T3 priority: irq_in[3] and [1] same cycle, all enabled edge -> vec_addr=8'h02 first; after rti_done -> 8'h04.
//   T4 masked pend: ENABLE=0, edge on src 0 -> no int_out, PEND=1; write ENABLE=1 -> int_out after 1 cycle.
//   T5 withdraw: level src 1 high then low in REQ without ack -> int_out drops, IDLE; ack with drop -> SERVICE.
//   T6 W1C race: edge on src 0 same cycle as PEND W1C bit 0 -> PEND[0] stays 1.

Source files
------------

// File: rtl/int_ctrl_multi.sv
// int_ctrl_multi: multi-source interrupt controller.
// Synchronises NUM_SRC asynchronous interrupt lines, latches them per source
// as edge or level pendings, masks them with ENABLE and presents the
// lowest-index eligible source to the core as a single request with a
// vector-table address. One interrupt is in flight at a time: the request is
// held until int_ack, and the source stays in service until rti_done.
module int_ctrl_multi #(
  parameter int                NUM_SRC     = 4,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] VEC_BASE    = 8'h01,
  parameter int                SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [DATA_W-1:0]  cfg_wdata,
  output logic [DATA_W-1:0]  cfg_rdata,
  output logic               int_out,
  input  logic               int_ack,
  output logic [DATA_W-1:0]  vec_addr,
  input  logic               rti_done,
  output logic               busy
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] ADDR_ENABLE = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  // Lowest-index set bit of a request vector (zero when none is set).
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      r = v[i] ? ID_W'(i) : r;
    end
    return r;
  endfunction

  // Synchroniser and edge detector
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0]                  prev_q;
  logic [NUM_SRC-1:0]                  sync_s;
  logic [NUM_SRC-1:0]                  edge_s;

  // Configuration and pending registers
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;

  // Arbitration / FSM
  state_t             state_q;
  logic [ID_W-1:0]    id_q;
  logic [DATA_W-1:0]  vec_addr_q;
  logic               int_out_q;
  logic               busy_q;
  logic [NUM_SRC-1:0] eligible_s;
  logic [ID_W-1:0]    win_s;
  logic [NUM_SRC-1:0] ack_clr_s;

  // Register read path
  logic [DATA_W-1:0]  status_s;
  logic [DATA_W-1:0]  rdata_d;
  logic [DATA_W-1:0]  cfg_rdata_q;

  logic en_wr_s, mode_wr_s, pend_wr_s;
  logic [NUM_SRC-1:0] wdata_src_s;

  assign sync_s      = sync_q[SYNC_STAGES-1];
  assign edge_s      = sync_s & ~prev_q;
  assign en_wr_s     = cfg_we && (cfg_addr == ADDR_ENABLE);
  assign mode_wr_s   = cfg_we && (cfg_addr == ADDR_MODE);
  assign pend_wr_s   = cfg_we && (cfg_addr == ADDR_PEND);
  assign wdata_src_s = cfg_wdata[NUM_SRC-1:0];
  assign eligible_s  = pend_q & enable_q;
  assign win_s       = lowest_set(eligible_s);

  // Upper write-data bits carry no configuration when NUM_SRC < DATA_W.
  generate
    if (NUM_SRC < DATA_W) begin : g_wdata_pad
      logic wdata_unused_s;
      assign wdata_unused_s = ^cfg_wdata[DATA_W-1:NUM_SRC];
    end
  endgenerate

  // Shift raw lines through the synchroniser, then keep one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      prev_q <= sync_s;
    end
  end

  // Pending-clear request from the core accepting the latched source.
  always_comb begin
    ack_clr_s = '0;
    if ((state_q == ST_REQ) && int_ack) begin
      ack_clr_s[id_q] = 1'b1;
    end else begin
      ack_clr_s = '0;
    end
  end

  // Next ENABLE/MODE from full-width config writes.
  always_comb begin
    if (en_wr_s) begin
      enable_d = wdata_src_s;
    end else begin
      enable_d = enable_q;
    end
    if (mode_wr_s) begin
      mode_d = wdata_src_s;
    end else begin
      mode_d = mode_q;
    end
  end

  // Next PEND: level sources track the synced line; edge sources latch, with a new edge beating any clear.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!mode_q[i]) begin
        // Switching level->edge discards the level state; only a coincident edge survives.
        if (mode_wr_s && wdata_src_s[i]) begin
          pend_d[i] = edge_s[i];
        end else begin
          pend_d[i] = sync_s[i];
        end
      end else begin
        if (edge_s[i]) begin
          pend_d[i] = 1'b1;
        end else if ((pend_wr_s && wdata_src_s[i]) || ack_clr_s[i]) begin
          pend_d[i] = 1'b0;
        end else begin
          pend_d[i] = pend_q[i];
        end
      end
    end
  end

  // Configuration and pending state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
    end else begin
      enable_q <= enable_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
    end
  end

  // Request/service FSM with registered core-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      vec_addr_q <= VEC_BASE;
      int_out_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|eligible_s) begin
            state_q    <= ST_REQ;
            id_q       <= win_s;
            vec_addr_q <= VEC_BASE + DATA_W'(win_s);
            int_out_q  <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            int_out_q  <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        ST_REQ: begin
          // Acknowledge takes precedence over a simultaneous withdrawal.
          if (int_ack) begin
            state_q   <= ST_SVC;
            int_out_q <= 1'b0;
            busy_q    <= 1'b1;
          end else if (!eligible_s[id_q]) begin
            state_q   <= ST_IDLE;
            int_out_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            int_out_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_SVC: begin
          int_out_q <= 1'b0;
          if (rti_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          int_out_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // STATUS word: {busy, in_service, id}, zero-padded.
  always_comb begin
    status_s = '0;
    status_s[ID_W+1:0] = {busy_q, (state_q == ST_SVC), id_q};
  end

  // Read-data mux for the addressed register.
  always_comb begin
    rdata_d = '0;
    case (cfg_addr)
      ADDR_ENABLE: rdata_d[NUM_SRC-1:0] = enable_q;
      ADDR_MODE:   rdata_d[NUM_SRC-1:0] = mode_q;
      ADDR_PEND:   rdata_d[NUM_SRC-1:0] = pend_q;
      ADDR_STATUS: rdata_d = status_s;
      default:     rdata_d = '0;
    endcase
  end

  // Registered read data, one cycle behind cfg_addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rdata_q <= '0;
    end else begin
      cfg_rdata_q <= rdata_d;
    end
  end

  assign cfg_rdata = cfg_rdata_q;
  assign int_out   = int_out_q;
  assign vec_addr  = vec_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_int_ctrl_multi.sv
// Self-checking bench for int_ctrl_multi: directed scenarios with fixed
// expectations, plus a randomized run compared against a reference model.
module tb_int_ctrl_multi;

  logic       clk;
  logic       rst;
  logic [3:0] irq_in;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       int_out;
  logic       int_ack;
  logic [7:0] vec_addr;
  logic       rti_done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] m_en, m_mode, m_pend;
  int         m_state;   // 0 idle, 1 requesting, 2 in service
  int         m_id;
  logic [7:0] m_vec;
  logic [7:0] m_rdata;
  logic       m_int, m_busy;
  logic [3:0] hist[$];   // hist[0] = irq_in sampled at the most recent edge

  int_ctrl_multi dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .int_out  (int_out),
    .int_ack  (int_ack),
    .vec_addr (vec_addr),
    .rti_done (rti_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_en = 4'h0; m_mode = 4'h0; m_pend = 4'h0;
    m_state = 0; m_id = 0; m_vec = 8'h01; m_rdata = 8'h00;
    m_int = 1'b0; m_busy = 1'b0;
    hist = {4'h0, 4'h0, 4'h0};
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_tick();
    logic [3:0] sync_v, prev_v, edg, elig, npend, nen, nmode;
    int nstate;
    int win;
    if (rst) begin
      model_reset();
      return;
    end
    // A line sampled high at edge k shows up as pending at edge k+2.
    sync_v = hist[1];
    prev_v = hist[2];
    edg    = sync_v & ~prev_v;
    elig   = m_pend & m_en;
    case (cfg_addr)
      2'd0:    m_rdata = {4'h0, m_en};
      2'd1:    m_rdata = {4'h0, m_mode};
      2'd2:    m_rdata = {4'h0, m_pend};
      default: m_rdata = {4'h0, (m_state != 0), (m_state == 2), 2'(m_id)};
    endcase
    nen   = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[3:0] : m_en;
    nmode = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[3:0] : m_mode;
    for (int i = 0; i < 4; i++) begin
      if (!m_mode[i]) begin
        if (cfg_we && cfg_addr == 2'd1 && cfg_wdata[i]) npend[i] = edg[i];
        else npend[i] = sync_v[i];
      end else begin
        npend[i] = m_pend[i];
        if ((cfg_we && cfg_addr == 2'd2 && cfg_wdata[i]) ||
            (m_state == 1 && int_ack && m_id == i)) npend[i] = 1'b0;
        if (edg[i]) npend[i] = 1'b1;
      end
    end
    nstate = m_state;
    if (m_state == 0) begin
      if (elig != 4'h0) begin
        win = 0;
        for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
        nstate = 1;
        m_id   = win;
        m_vec  = 8'(1 + win);
      end
    end else if (m_state == 1) begin
      if (int_ack) nstate = 2;
      else if (!elig[m_id]) nstate = 0;
    end else begin
      if (rti_done) nstate = 0;
    end
    m_state = nstate;
    m_int   = (m_state == 1);
    m_busy  = (m_state != 0);
    m_pend  = npend;
    m_en    = nen;
    m_mode  = nmode;
    hist.push_front(irq_in);
    void'(hist.pop_back());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; irq_in = 4'h0; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_wdata = 8'h00; int_ack = 1'b0; rti_done = 1'b0;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; cycle(); int_ack = 1'b0;
  endtask

  task automatic pulse_rti();
    rti_done = 1'b1; cycle(); rti_done = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    cfg_write(2'd0, 8'h01);
    cfg_write(2'd1, 8'h01);
    irq_in = 4'b0001; cycle(); irq_in = 4'h0;
    repeat (3) cycle();
    pulse_ack();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_in_service busy got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL t1_int_out got %b want 0", int_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy got %b want 0", busy); end
    checks++; if (vec_addr !== 8'h01) begin errors++; $display("FAIL t1_vec got %h want 01", vec_addr); end
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      cycle();
      checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL t1_reg%0d got %h want 00", a, cfg_rdata); end
    end
  endtask

  task automatic test_single_edge();
    apply_reset();
    cfg_write(2'd0, 8'h04);
    cfg_write(2'd1, 8'h04);
    irq_in = 4'b0100; cycle();
    irq_in = 4'h0; cycle(); cycle();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL t2_early got %b want 0", int_out); end
    cycle();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL t2_int_out got %b want 1", int_out); end
    checks++; if (vec_addr !== 8'h03) begin errors++; $display("FAIL t2_vec got %h want 03", vec_addr); end
    pulse_ack();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL t2_ack_int got %b want 0", int_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t2_ack_busy got %b want 1", busy); end
    cfg_addr = 2'd2; cycle();
    checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL t2_pend got %h want 00", cfg_rdata); end
    pulse_rti();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_rti_busy got %b want 0", busy); end
  endtask

  task automatic test_priority();
    apply_reset();
    cfg_write(2'd0, 8'h0F);
    cfg_write(2'd1, 8'h0F);
    irq_in = 4'b1010; cycle(); irq_in = 4'h0;
    repeat (3) cycle();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL t3_first_int got %b want 1", int_out); end
    checks++; if (vec_addr !== 8'h02) begin errors++; $display("FAIL t3_first_vec got %h want 02", vec_addr); end
    pulse_ack();
    repeat (2) cycle();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL t3_service_int got %b want 0", int_out); end
    pulse_rti();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL t3_idle_int got %b want 0", int_out); end
    cycle();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL t3_second_int got %b want 1", int_out); end
    checks++; if (vec_addr !== 8'h04) begin errors++; $display("FAIL t3_second_vec got %h want 04", vec_addr); end
    pulse_ack();
    pulse_rti();
  endtask

  task automatic test_masked_pend();
    apply_reset();
    cfg_write(2'd1, 8'h0F);
    irq_in = 4'b0001; cycle(); irq_in = 4'h0;
    repeat (4) cycle();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL t4_masked_int got %b want 0", int_out); end
    cfg_addr = 2'd2; cycle();
    checks++; if (cfg_rdata !== 8'h01) begin errors++; $display("FAIL t4_pend got %h want 01", cfg_rdata); end
    cfg_write(2'd0, 8'h01);
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL t4_write_edge got %b want 0", int_out); end
    cycle();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL t4_unmask_int got %b want 1", int_out); end
    checks++; if (vec_addr !== 8'h01) begin errors++; $display("FAIL t4_vec got %h want 01", vec_addr); end
    pulse_ack();
    pulse_rti();
  endtask

  task automatic test_withdraw();
    apply_reset();
    cfg_write(2'd0, 8'h02);
    irq_in = 4'b0010;
    repeat (4) cycle();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL t5_req got %b want 1", int_out); end
    checks++; if (vec_addr !== 8'h02) begin errors++; $display("FAIL t5_vec got %h want 02", vec_addr); end
    irq_in = 4'h0;
    repeat (3) cycle();
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL t5_hold got %b want 1", int_out); end
    cycle();
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL t5_drop_int got %b want 0", int_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_drop_busy got %b want 0", busy); end
    irq_in = 4'b0010;
    repeat (4) cycle();
    irq_in = 4'h0;
    repeat (3) cycle();
    pulse_ack();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_ack_wins got %b want 1", busy); end
    cfg_addr = 2'd3; cycle();
    checks++; if (cfg_rdata !== 8'h0D) begin errors++; $display("FAIL t5_status got %h want 0d", cfg_rdata); end
    pulse_rti();
  endtask

  task automatic test_w1c_race();
    apply_reset();
    cfg_write(2'd1, 8'h01);
    irq_in = 4'b0001; cycle();
    irq_in = 4'h0; cycle();
    cfg_write(2'd2, 8'h01);
    cfg_addr = 2'd2; cycle();
    checks++; if (cfg_rdata !== 8'h01) begin errors++; $display("FAIL t6_set_wins got %h want 01", cfg_rdata); end
    cfg_write(2'd2, 8'h01);
    cfg_addr = 2'd2; cycle();
    checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL t6_w1c got %h want 00", cfg_rdata); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      irq_in    = irq_in ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 2'($urandom);
      cfg_wdata = 8'($urandom);
      int_ack   = ($urandom_range(0, 2) == 0);
      rti_done  = ($urandom_range(0, 3) == 0);
      cycle();
      checks++; if (int_out !== m_int) begin errors++; $display("FAIL rnd_int_out cyc %0d got %b want %b", n, int_out, m_int); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", n, busy, m_busy); end
      checks++; if (vec_addr !== m_vec) begin errors++; $display("FAIL rnd_vec cyc %0d got %h want %h", n, vec_addr, m_vec); end
      checks++; if (cfg_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h want %h", n, cfg_rdata, m_rdata); end
    end
    cfg_we = 1'b0; int_ack = 1'b0; rti_done = 1'b0; irq_in = 4'h0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'h0; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_wdata = 8'h00; int_ack = 1'b0; rti_done = 1'b0;
    model_reset();
    test_reset();
    test_single_edge();
    test_priority();
    test_masked_pend();
    test_withdraw();
    test_w1c_race();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
